// File: rtl/mult8_acc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mult8_acc_pkg : shared types and helpers for the product accumulator |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
package mult8_acc_pkg;

  localparam int PROD_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  function automatic int cnt_width(input int max_terms);
    return $clog2(max_terms + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mult8_acc_adder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | acc_adder : ACC_W-bit unsigned adder with carry out                  |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module acc_adder #(
  parameter int ACC_W = 24
) (
  input  logic [ACC_W-1:0] a,
  input  logic [ACC_W-1:0] b,
  output logic [ACC_W-1:0] sum,
  output logic             carry
);

  assign {carry, sum} = {1'b0, a} + {1'b0, b};

endmodule
`default_nettype wire

// File: rtl/mult8_acc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mult8_acc : streaming group accumulator for 16-bit products          |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module mult8_acc
  import mult8_acc_pkg::*;
#(
  parameter  int ACC_W     = 24,
  parameter  int MAX_TERMS = 256,
  localparam int CNT_W     = cnt_width(MAX_TERMS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic [PROD_W-1:0] in_prod,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_ovf,
  output logic              out_trunc,
  output logic              out_valid,
  input  logic              out_ready
);

  state_t             r_state, w_state_next;
  logic [ACC_W-1:0]   r_acc, w_acc_next;
  logic [CNT_W-1:0]   r_cnt, w_cnt_next;
  logic               r_ovf, w_ovf_next;
  logic [ACC_W-1:0]   w_add_sum;
  logic               w_add_carry;
  logic               w_beat;
  logic               w_limit;
  logic               w_load;
  logic               w_trunc;

  acc_adder #(.ACC_W(ACC_W)) u_adder (
    .a     (r_acc),
    .b     (ACC_W'(in_prod)),
    .sum   (w_add_sum),
    .carry (w_add_carry)
  );

  assign in_ready  = (r_state != HOLD);
  assign out_valid = (r_state == HOLD);
  assign w_beat    = in_valid & in_ready & ~clear;

  always_comb begin
    w_state_next = r_state;
    w_acc_next   = r_acc;
    w_cnt_next   = r_cnt;
    w_ovf_next   = r_ovf;
    w_limit      = 1'b0;
    w_load       = 1'b0;
    w_trunc      = 1'b0;
    if (clear) begin
      w_state_next = IDLE;
      w_acc_next   = '0;
      w_cnt_next   = '0;
      w_ovf_next   = 1'b0;
    end else begin
      case (r_state)
        IDLE, ACCUM: begin
          if (w_beat) begin
            if (r_state == IDLE) begin
              w_acc_next = ACC_W'(in_prod);
              w_cnt_next = CNT_W'(1);
              w_ovf_next = 1'b0;
            end else begin
              w_acc_next = w_add_sum;
              w_cnt_next = r_cnt + CNT_W'(1);
              w_ovf_next = r_ovf | w_add_carry;
            end
            // Limit is judged on the post-update count so the MAX_TERMS-th beat closes.
            w_limit      = (w_cnt_next == CNT_W'(MAX_TERMS));
            w_load       = in_last | w_limit;
            w_trunc      = w_limit & ~in_last;
            w_state_next = w_load ? HOLD : ACCUM;
          end
        end
        HOLD: begin
          if (out_ready) w_state_next = IDLE;
        end
        default: w_state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_ovf     <= 1'b0;
      out_sum   <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
      out_trunc <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_acc   <= w_acc_next;
      r_cnt   <= w_cnt_next;
      r_ovf   <= w_ovf_next;
      if (w_load) begin
        out_sum   <= w_acc_next;
        out_count <= w_cnt_next;
        out_ovf   <= w_ovf_next;
        out_trunc <= w_trunc;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mult8_acc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mult8_acc : directed self-checking bench for mult8_acc            |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_mult8_acc;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic [15:0] in_prod = '0;
  logic        in_valid0 = 1'b0;
  logic        in_valid1 = 1'b0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b0;

  logic        in_ready0, out_ovf0, out_trunc0, out_valid0;
  logic [23:0] out_sum0;
  logic [8:0]  out_count0;
  logic        in_ready1, out_ovf1, out_trunc1, out_valid1;
  logic [15:0] out_sum1;
  logic [2:0]  out_count1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mult8_acc u_dut0 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_prod(in_prod),
    .in_valid(in_valid0), .in_last(in_last), .in_ready(in_ready0),
    .out_sum(out_sum0), .out_count(out_count0), .out_ovf(out_ovf0),
    .out_trunc(out_trunc0), .out_valid(out_valid0), .out_ready(out_ready)
  );

  mult8_acc #(.ACC_W(16), .MAX_TERMS(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_prod(in_prod),
    .in_valid(in_valid1), .in_last(in_last), .in_ready(in_ready1),
    .out_sum(out_sum1), .out_count(out_count1), .out_ovf(out_ovf1),
    .out_trunc(out_trunc1), .out_valid(out_valid1), .out_ready(out_ready)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++; if (out_valid0 !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0d expected 0", out_valid0); end
    checks++; if (in_ready0 !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0d expected 1", in_ready0); end
    checks++; if ({out_sum0, out_count0, out_ovf0, out_trunc0} !== '0) begin errors++; $display("FAIL reset_outs: got sum=%0d cnt=%0d ovf=%0d trunc=%0d expected all 0", out_sum0, out_count0, out_ovf0, out_trunc0); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_three_term();
    out_ready = 1'b0;
    in_valid0 = 1'b1; in_prod = 16'd65025; in_last = 1'b0;
    tick();
    in_prod = 16'd6;
    tick();
    checks++; if (out_valid0 !== 1'b0) begin errors++; $display("FAIL three_early_valid: got %0d expected 0", out_valid0); end
    in_prod = 16'd1; in_last = 1'b1;
    tick();
    in_valid0 = 1'b0; in_last = 1'b0;
    checks++; if (out_valid0 !== 1'b1) begin errors++; $display("FAIL three_valid: got %0d expected 1", out_valid0); end
    checks++; if (out_sum0 !== 24'd65032) begin errors++; $display("FAIL three_sum: got %0d expected 65032", out_sum0); end
    checks++; if (out_count0 !== 9'd3) begin errors++; $display("FAIL three_count: got %0d expected 3", out_count0); end
    checks++; if ({out_ovf0, out_trunc0} !== 2'b00) begin errors++; $display("FAIL three_flags: got ovf=%0d trunc=%0d expected 0 0", out_ovf0, out_trunc0); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++; if ({out_valid0, in_ready0} !== 2'b01) begin errors++; $display("FAIL three_release: got valid=%0d ready=%0d expected 0 1", out_valid0, in_ready0); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    in_valid0 = 1'b1; in_prod = 16'd100; in_last = 1'b1;
    tick();
    in_prod = 16'd7; in_last = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++; if ({out_valid0, in_ready0, out_sum0} !== {1'b1, 1'b0, 24'd100}) begin errors++; $display("FAIL bp_hold[%0d]: got valid=%0d ready=%0d sum=%0d expected 1 0 100", i, out_valid0, in_ready0, out_sum0); end
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++; if ({out_valid0, in_ready0} !== 2'b01) begin errors++; $display("FAIL bp_handshake: got valid=%0d ready=%0d expected 0 1", out_valid0, in_ready0); end
    in_last = 1'b1;
    tick();
    in_valid0 = 1'b0; in_last = 1'b0;
    checks++; if ({out_valid0, out_sum0, out_count0} !== {1'b1, 24'd7, 9'd1}) begin errors++; $display("FAIL bp_new_group: got valid=%0d sum=%0d cnt=%0d expected 1 7 1", out_valid0, out_sum0, out_count0); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_term_limit();
    in_valid1 = 1'b1; in_prod = 16'd65025; in_last = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (out_valid1 !== 1'b0) begin errors++; $display("FAIL limit_early[%0d]: got %0d expected 0", i, out_valid1); end
      tick();
    end
    in_valid1 = 1'b0;
    checks++; if ({out_valid1, in_ready1} !== 2'b10) begin errors++; $display("FAIL limit_valid: got valid=%0d ready=%0d expected 1 0", out_valid1, in_ready1); end
    checks++; if ({out_sum1, out_count1} !== {16'd63492, 3'd4}) begin errors++; $display("FAIL limit_sum: got sum=%0d cnt=%0d expected 63492 4", out_sum1, out_count1); end
    checks++; if ({out_ovf1, out_trunc1} !== 2'b11) begin errors++; $display("FAIL limit_flags: got ovf=%0d trunc=%0d expected 1 1", out_ovf1, out_trunc1); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    // last flag coinciding with the limit is not a truncation
    in_valid1 = 1'b1; in_prod = 16'd1;
    for (int i = 0; i < 4; i++) begin
      in_last = (i == 3);
      tick();
    end
    in_valid1 = 1'b0; in_last = 1'b0;
    checks++; if ({out_valid1, out_sum1, out_count1, out_ovf1, out_trunc1} !== {1'b1, 16'd4, 3'd4, 1'b0, 1'b0}) begin errors++; $display("FAIL limit_last: got valid=%0d sum=%0d cnt=%0d ovf=%0d trunc=%0d expected 1 4 4 0 0", out_valid1, out_sum1, out_count1, out_ovf1, out_trunc1); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_clear();
    in_valid0 = 1'b1; in_prod = 16'd10; in_last = 1'b0;
    tick();
    tick();
    clear = 1'b1; in_prod = 16'd5; in_last = 1'b1;
    tick();
    clear = 1'b0; in_valid0 = 1'b0; in_last = 1'b0;
    checks++; if (out_valid0 !== 1'b0) begin errors++; $display("FAIL clear_valid: got %0d expected 0", out_valid0); end
    tick();
    checks++; if (out_valid0 !== 1'b0) begin errors++; $display("FAIL clear_valid_later: got %0d expected 0", out_valid0); end
    in_valid0 = 1'b1; in_prod = 16'd9; in_last = 1'b1;
    tick();
    in_valid0 = 1'b0; in_last = 1'b0;
    checks++; if ({out_valid0, out_sum0, out_count0} !== {1'b1, 24'd9, 9'd1}) begin errors++; $display("FAIL clear_next: got valid=%0d sum=%0d cnt=%0d expected 1 9 1", out_valid0, out_sum0, out_count0); end
    clear = 1'b1; out_ready = 1'b1;
    tick();
    clear = 1'b0; out_ready = 1'b0;
    checks++; if ({out_valid0, in_ready0} !== 2'b01) begin errors++; $display("FAIL clear_hold: got valid=%0d ready=%0d expected 0 1", out_valid0, in_ready0); end
  endtask

  task automatic test_async_reset();
    in_valid0 = 1'b1; in_prod = 16'd50; in_last = 1'b1;
    tick();
    in_valid0 = 1'b0; in_last = 1'b0;
    checks++; if (out_valid0 !== 1'b1) begin errors++; $display("FAIL arst_pre: got %0d expected 1", out_valid0); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({out_valid0, in_ready0, out_sum0} !== {1'b0, 1'b1, 24'd0}) begin errors++; $display("FAIL arst_drop: got valid=%0d ready=%0d sum=%0d expected 0 1 0", out_valid0, in_ready0, out_sum0); end
    rst_n = 1'b1;
    tick();
    in_valid0 = 1'b1; in_prod = 16'd20;
    tick();
    in_prod = 16'd30; in_last = 1'b1;
    tick();
    in_valid0 = 1'b0; in_last = 1'b0;
    checks++; if ({out_valid0, out_sum0, out_count0} !== {1'b1, 24'd50, 9'd2}) begin errors++; $display("FAIL arst_next: got valid=%0d sum=%0d cnt=%0d expected 1 50 2", out_valid0, out_sum0, out_count0); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_three_term();
    test_back_to_back();
    test_term_limit();
    test_clear();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
